// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: shared types, register map and status bit positions for the MMIO UART transmitter
package mmio_uart_tx_pkg;
  typedef enum logic [1:0] {DT_BYTE, DT_HALF, DT_WORD} mem_dt_e;
  typedef enum logic [1:0] {ENONE, EALIGN} errno_e;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV = 2'd2;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT = 4;
  function automatic logic [3:0] sat4(input logic [31:0] v);
    return (v > 32'd15) ? 4'hf : v[3:0];
  endfunction
endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: cpu data-port bus seen by the UART register window
interface mmio_uart_tx_if;
  import mmio_uart_tx_pkg::*;
  logic [31:0] addr;
  logic we;
  logic [31:0] wd;
  mem_dt_e dt;
  logic sel;
  logic [31:0] rd;
  errno_e err;
  modport master(output addr, we, wd, dt, input sel, rd, err);
  modport slave(input addr, we, wd, dt, output sel, rd, err);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: circular-buffer FIFO with wrap-around pointers and an occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and programmable bit divisor
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic clk,
  input  logic rst,
  mmio_uart_tx_if.slave bus,
  output logic tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] off, status;
  logic [1:0] widx;
  logic ok, wr, wr_data, push, pop, full, empty, ovf, bit_end, unused_wd;
  logic [CW-1:0] count;
  logic [7:0] head, shift;
  logic [15:0] div, div_l, cnt;
  logic [2:0] idx;
  uart_tx_state_e state, state_n;
  assign off = bus.addr - BASE_ADDR;
  assign widx = off[3:2];
  assign bus.sel = off < 32'd12;
  assign bus.err = !bus.sel ? ENONE
                 : (off[1:0] != 2'b00) ? EALIGN
                 : (widx == REG_DATA) ? ((bus.dt == DT_BYTE || bus.dt == DT_WORD) ? ENONE : EALIGN)
                 : (bus.dt == DT_WORD) ? ENONE : EALIGN;
  assign ok = bus.sel && bus.err == ENONE;
  assign wr = ok && bus.we;
  assign wr_data = wr && widx == REG_DATA;
  assign push = wr_data && !full;
  assign status = {24'h0, sat4(32'(count)), ovf, empty, full, state != IDLE};
  assign bus.rd = (ok && !bus.we) ? (widx == REG_STATUS ? status : widx == REG_DIV ? {16'h0, div} : 32'h0) : 32'h0;
  assign unused_wd = ^bus.wd[31:16];
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(bus.wd[7:0]),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign bit_end = cnt <= 16'd1;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    tx = 1'b1;
    unique case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
      START: begin
        tx = 1'b0;
        state_n = bit_end ? DATA : START;
      end
      DATA: begin
        tx = shift[0];
        state_n = (bit_end && idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      div_l <= '0;
      div <= DEFAULT_DIV;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      // popping restarts a frame; the divisor is sampled only here
      if (pop) begin
        shift <= head;
        div_l <= div;
        cnt <= div;
        idx <= '0;
      end else if (state != IDLE) begin
        cnt <= bit_end ? div_l : cnt - 16'd1;
        if (state == DATA && bit_end) begin
          shift <= shift >> 1;
          idx <= idx + 3'd1;
        end
      end
      ovf <= (wr_data && full) ? 1'b1 : (wr && widx == REG_STATUS && bus.wd[ST_OVF]) ? 1'b0 : ovf;
      if (wr && widx == REG_DIV) div <= (bus.wd[15:0] == 16'h0) ? 16'd1 : bus.wd[15:0];
    end
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the cpu data port (d_addr/d_we/d_wd/d_dt in, d_rd out), in parallel with the data half of cpu_mem.
- A store to DATA pushes one byte into a TX FIFO; an FSM serialises bytes 8N1, LSB first, on tx.
- Reads are combinational so the single-cycle cpu can read status (for example, a poll on the full flag) in the same cycle.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of the register window (3 words, 16-byte aligned).
- FIFO_DEPTH, 8, TX FIFO entries (power of two, ≥2).
- DEFAULT_DIV, 16'd16, clocks per bit after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  data address from cpu.
- we  in  1  write enable from cpu.
- wd  in  32  write data.
- dt  in  mem_dt_e  access width (byte/half/word).
- sel  out  1  addr within BASE_ADDR..BASE_ADDR+11; combinational.
- rd  out  32  read data; combinational; 0 when !sel.
- err  out  errno_e  access error; combinational; ENONE when !sel.
- tx  out  1  serial line; idle high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high: sampled only on the clk rising edge.
- Register map, offsets from BASE_ADDR:
  - 0x0 DATA: write only; reads return 0.
  - 0x4 STATUS: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count (saturates at 15), other bits 0.
  - 0x8 DIV: bits[15:0] r/w; upper bits read 0.
- Access errors: addr[1:0]!=0 -> err=EALIGN, no side effect. STATUS/DIV accessed with non-word dt -> err=EALIGN, no side effect. DATA accepts byte or word and uses wd[7:0].
- DATA write while FIFO not full: push at edge. Full check uses the pre-edge count, so a push while full is dropped and sets overflow, even if a pop occurs the same cycle.
- STATUS write with wd[3]=1: clears overflow. If an overflow event occurs the same cycle, set wins.
- DIV write: stored value 0 is clamped to 1. Divisor is latched into the FSM at each frame start; mid-frame writes affect the next frame only.
- FSM states: IDLE, START, DATA, STOP. Each bit lasts div_latched clocks, counted by a 16-bit down-counter.
  - IDLE: tx=1. If FIFO non-empty at an edge, pop the head into an 8-bit shift register, latch div, enter START.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right after each bit. 3-bit bit index, exits after bit 7.
  - STOP: tx=1. At its end, if FIFO non-empty, pop and enter START directly (no idle gap); else IDLE.
- Latency: DATA write at edge N -> tx falls after edge N+1. A frame is exactly 10*div clocks.
- FIFO: circular buffer with wrap-around pointers; count 0..FIFO_DEPTH. Simultaneous push and pop when not full and not empty: count unchanged.
- Reset (including mid-frame), after the edge: tx=1, FSM=IDLE, FIFO empty, overflow=0, DIV=DEFAULT_DIV, counters 0. The partial frame is abandoned.
- rd/err are pure functions of addr/dt/we and current state. A write sees pre-edge state.

Decomposition:
- Header mmio_uart.svh:
  - register offset constants;
  - STATUS bit index constants;
  - uart_tx_state_e {IDLE, START, DATA, STOP}.
- EALIGN is added to errno.svh alongside ENONE.
- Sub-module sync_fifo (params WIDTH=8, DEPTH): push/pop/full/empty/count, synchronous reset.
- The FSM and bus decode stay in mmio_uart_tx.

Test Plan:
- Reset, then word read at 0x1004 -> rd=32'h0000_0004 (empty only), tx=1. Read at 0x1008 -> 16.
- DIV=4, write 0x55 to DATA -> tx low for cycles 1-4 after the edge following the write. Then bits 1,0,1,0,1,0,1,0 and a stop bit, each 4 clocks; total 40 clocks. busy=1 throughout, then busy=0.
- DIV=2, FIFO_DEPTH=8, 10 back-to-back byte writes (0x00..0x09) -> first byte is popped one edge after its write, so 8 entries remain after the 9th write. 10th write dropped, overflow=1, count=8. Serial output is 0x00..0x08 with no idle gap between frames. STATUS write 0x8 clears overflow.
- Unaligned or narrow accesses: word read at 0x1006, or byte write to DIV -> err=EALIGN, DIV unchanged, no push. Access at 0x2000 -> sel=0, rd=0, err=ENONE.
- Reset asserted mid-frame (DIV=4, after bit 3) -> tx=1 at the next edge, STATUS=0x4, DIV=16. A new write transmits a full, correct frame.
- Integration: cpu program does sw 0x41 to 0x1000, then polls lw 0x1004 until bit2 set -> decoded tx frame equals 0x41 and the loop exits.
